// File: rtl/param_sync_fifo_if.sv
// Producer/consumer handshake bundle for param_sync_fifo.
// The FIFO takes the slave modport; the environment drives through master.
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    logic [DATA_WIDTH-1:0]        data_in;
    logic                         wr_en;
    logic                         rd_en;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         wr_ack;
    logic                         overflow;
    logic                         underflow;
    logic                         full;
    logic                         empty;
    logic                         almostfull;
    logic                         almostempty;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with configurable width/depth, threshold flags, occupancy
// count and optional first-word-fall-through read data.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    param_sync_fifo_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full   = (count == FULL_CNT);
        empty  = (count == '0);
        rd_acc = bus.rd_en && !empty;
        wr_acc = bus.wr_en && (!full || rd_acc);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dout_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= next_ptr(rd_ptr);
                dout_q <= mem[rd_ptr];
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            wr_ack_q    <= wr_acc;
            overflow_q  <= bus.wr_en && !wr_acc;
            underflow_q <= bus.rd_en && !rd_acc;
        end
    end

    // In FWFT mode dout_q still captures each popped word, so it is exactly
    // the value to hold once the FIFO runs empty; memory is registered, so
    // there is no path from data_in to data_out.
    generate
        if (FWFT) begin : g_fwft
            assign bus.data_out = empty ? dout_q : mem[rd_ptr];
        end else begin : g_reg
            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count >= AF_CNT) && (count < FULL_CNT);
    assign bus.almostempty = !empty && (count <= AE_CNT);
    assign bus.count       = count;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench: a registered-read FIFO (defaults) and an
// FWFT build with AE_LEVEL=2 share one clock and reset.
module tb_param_sync_fifo;
    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    param_sync_fifo_if #(.DATA_WIDTH(16), .DEPTH(8)) bus_reg ();
    param_sync_fifo_if #(.DATA_WIDTH(16), .DEPTH(8)) bus_fw  ();

    param_sync_fifo #(
        .DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b0)
    ) dut_reg (
        .clk(clk), .rst(rst), .bus(bus_reg.slave)
    );

    param_sync_fifo #(
        .DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(2), .FWFT(1'b1)
    ) dut_fw (
        .clk(clk), .rst(rst), .bus(bus_fw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests on the registered FIFO, then sample 1 ns after the edge.
    task automatic apply_stimulus(input logic wr, input logic rd, input logic [15:0] din);
        bus_reg.wr_en   = wr;
        bus_reg.rd_en   = rd;
        bus_reg.data_in = din;
        @(posedge clk);
        #1;
        bus_reg.wr_en = 1'b0;
        bus_reg.rd_en = 1'b0;
    endtask

    task automatic apply_fwft(input logic wr, input logic rd, input logic [15:0] din);
        bus_fw.wr_en   = wr;
        bus_fw.rd_en   = rd;
        bus_fw.data_in = din;
        @(posedge clk);
        #1;
        bus_fw.wr_en = 1'b0;
        bus_fw.rd_en = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        bus_reg.wr_en = 1'b0; bus_reg.rd_en = 1'b0; bus_reg.data_in = '0;
        bus_fw.wr_en  = 1'b0; bus_fw.rd_en  = 1'b0; bus_fw.data_in  = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_count", 32'(bus_reg.count), 0);
        check_output("rst_empty", 32'(bus_reg.empty), 1);
        check_output("rst_full", 32'(bus_reg.full), 0);
        check_output("rst_af", 32'(bus_reg.almostfull), 0);
        check_output("rst_ae", 32'(bus_reg.almostempty), 0);
        check_output("rst_dout", 32'(bus_reg.data_out), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Fill 0x1000..0x1007
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 16'h1000 + 16'(i));
            check_output($sformatf("fill_ack%0d", i), 32'(bus_reg.wr_ack), 1);
            check_output($sformatf("fill_cnt%0d", i), 32'(bus_reg.count), 32'(i + 1));
            check_output($sformatf("fill_af%0d", i), 32'(bus_reg.almostfull), (i == 6) ? 1 : 0);
            check_output($sformatf("fill_full%0d", i), 32'(bus_reg.full), (i == 7) ? 1 : 0);
        end
        apply_stimulus(1'b1, 1'b0, 16'hDEAD);
        check_output("ovf_flag", 32'(bus_reg.overflow), 1);
        check_output("ovf_ack", 32'(bus_reg.wr_ack), 0);
        check_output("ovf_cnt", 32'(bus_reg.count), 8);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 16'h0);
            check_output($sformatf("drain_dout%0d", i), 32'(bus_reg.data_out), 32'h1000 + 32'(i));
            check_output($sformatf("drain_cnt%0d", i), 32'(bus_reg.count), 32'(7 - i));
            check_output($sformatf("drain_ae%0d", i), 32'(bus_reg.almostempty), (i == 6) ? 1 : 0);
            check_output($sformatf("drain_empty%0d", i), 32'(bus_reg.empty), (i == 7) ? 1 : 0);
            if (i == 0) check_output("ovf_not_sticky", 32'(bus_reg.overflow), 0);
        end
        apply_stimulus(1'b0, 1'b1, 16'h0);
        check_output("udf_flag", 32'(bus_reg.underflow), 1);
        check_output("udf_hold", 32'(bus_reg.data_out), 32'h1007);

        // Full with simultaneous read and write
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 16'h3000 + 16'(i));
        check_output("udf_not_sticky", 32'(bus_reg.underflow), 0);
        apply_stimulus(1'b1, 1'b1, 16'hBEEF);
        check_output("fullrw_cnt", 32'(bus_reg.count), 8);
        check_output("fullrw_ack", 32'(bus_reg.wr_ack), 1);
        check_output("fullrw_ovf", 32'(bus_reg.overflow), 0);
        check_output("fullrw_dout", 32'(bus_reg.data_out), 32'h3000);
        for (int i = 1; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 16'h0);
            check_output($sformatf("fullrw_rd%0d", i), 32'(bus_reg.data_out), 32'h3000 + 32'(i));
        end
        apply_stimulus(1'b0, 1'b1, 16'h0);
        check_output("beef_out", 32'(bus_reg.data_out), 32'hBEEF);
        check_output("beef_empty", 32'(bus_reg.empty), 1);

        // Empty with simultaneous read and write
        apply_stimulus(1'b1, 1'b1, 16'h00AA);
        check_output("emptyrw_cnt", 32'(bus_reg.count), 1);
        check_output("emptyrw_ack", 32'(bus_reg.wr_ack), 1);
        check_output("emptyrw_udf", 32'(bus_reg.underflow), 1);
        check_output("emptyrw_hold", 32'(bus_reg.data_out), 32'hBEEF);
        apply_stimulus(1'b0, 1'b1, 16'h0);
        check_output("emptyrw_rd", 32'(bus_reg.data_out), 32'h00AA);

        // Wrap-around
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 16'h4000 + 16'(i));
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 16'h0);
        check_output("wrap_pre", 32'(bus_reg.data_out), 32'h4004);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 16'h2000 + 16'(i));
            check_output($sformatf("wrap_full%0d", i), 32'(bus_reg.full), (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 16'h0);
            check_output($sformatf("wrap_rd%0d", i), 32'(bus_reg.data_out), 32'h2000 + 32'(i));
        end

        // Asynchronous reset mid-cycle
        apply_stimulus(1'b1, 1'b0, 16'h1234);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 16'h7000 + 16'(i));
        apply_stimulus(1'b1, 1'b1, 16'h5555);
        check_output("pre_rst_cnt", 32'(bus_reg.count), 5);
        check_output("pre_rst_dout", 32'(bus_reg.data_out), 32'h1234);
        check_output("pre_rst_ack", 32'(bus_reg.wr_ack), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("arst_cnt", 32'(bus_reg.count), 0);
        check_output("arst_empty", 32'(bus_reg.empty), 1);
        check_output("arst_dout", 32'(bus_reg.data_out), 0);
        check_output("arst_ack", 32'(bus_reg.wr_ack), 0);
        check_output("arst_flags", {29'b0, bus_reg.overflow, bus_reg.underflow, bus_reg.almostempty}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        apply_stimulus(1'b0, 1'b1, 16'h0);
        check_output("arst_udf", 32'(bus_reg.underflow), 1);
        check_output("arst_udf_dout", 32'(bus_reg.data_out), 0);

        // FWFT build
        check_output("fw_rst_dout", 32'(bus_fw.data_out), 0);
        check_output("fw_rst_empty", 32'(bus_fw.empty), 1);
        apply_fwft(1'b1, 1'b0, 16'hABCD);
        check_output("fw_first", 32'(bus_fw.data_out), 32'hABCD);
        check_output("fw_first_empty", 32'(bus_fw.empty), 0);
        check_output("fw_first_ae", 32'(bus_fw.almostempty), 1);
        apply_fwft(1'b1, 1'b0, 16'h5678);
        check_output("fw_second_ae", 32'(bus_fw.almostempty), 1);
        check_output("fw_second_cnt", 32'(bus_fw.count), 2);
        check_output("fw_second_dout", 32'(bus_fw.data_out), 32'hABCD);
        apply_fwft(1'b0, 1'b1, 16'h0);
        check_output("fw_pop_dout", 32'(bus_fw.data_out), 32'h5678);
        check_output("fw_pop_cnt", 32'(bus_fw.count), 1);
        apply_fwft(1'b0, 1'b1, 16'h0);
        check_output("fw_drain_empty", 32'(bus_fw.empty), 1);
        check_output("fw_drain_hold", 32'(bus_fw.data_out), 32'h5678);
        apply_fwft(1'b0, 1'b1, 16'h0);
        check_output("fw_udf", 32'(bus_fw.underflow), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
